msg_frame_parser: RTL and testbench
===================================

Name: msg_frame_parser

Overview:
Parametrised successor to the fixed-format UART message checker. It consumes bytes from the UART receiver and parses ASCII frames of the form `{T0ddd,T1ddd,...}`. Each field is decoded on the fly into a binary value, not a packed ASCII buffer. It also parses LED frames `{Lddd}`. Faults are reported with an error code, and the block adds an inter-byte timeout and resynchronisation on `{`. It sits between the UART RX and the RGB/LED command consumers.

Parameters:
- N_FIELDS, 3: number of tagged fields in an RGB frame (1..8).
- DIGITS, 3: exact decimal digit count per field, leading zeros required (1..5).
- MAX_VAL, 255: largest legal RGB field value.
- TAGS, {"B","G","R"}: N_FIELDS x 8-bit tag characters; TAGS[i] tags field i.
- LED_MIN, 16: smallest legal LED command value.
- LED_MAX, 17: largest legal LED command value.
- TIMEOUT_CYC, 100000: idle cycles allowed between bytes inside a frame.
- VAL_W, $clog2(MAX_VAL+1): derived width of one field; not overridable.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- rx_byte, in, 8: received byte; valid only when rx_done is high.
- rx_done, in, 1: one-cycle strobe, byte available.
- rgb_fields, out, N_FIELDS*VAL_W: decoded fields; field i occupies [i*VAL_W +: VAL_W].
- rgb_ready, out, 1: one-cycle pulse, rgb_fields updated.
- led_command, out, 8: decoded LED command value.
- led_cmd_ready, out, 1: one-cycle pulse, led_command updated.
- shift_buff, out, 1: one-cycle pulse for each rx_done.
- frame_err, out, 1: one-cycle pulse on frame abort.
- err_code, out, 3: cause of the last error; held until the next error.
- busy, out, 1: high while a frame is in progress (state is not IDLE).

Behaviour:
Reset values:
- All outputs are 0; state is IDLE; all counters and accumulators are 0.
- Reset asserted mid-frame discards the frame with no error pulse.

Latency:
- All outputs are registered.
- rgb_ready, led_cmd_ready, frame_err and shift_buff pulse in the cycle after the rx_done that caused them.
- rgb_fields and led_command change only together with their ready pulse, so they are stable otherwise.

State machine:
- IDLE: on `{`, clear accumulators, set field index fi=0, go to TAG. Any other byte is ignored with no error.
- TAG: when fi==0, `L` selects LED mode and goes to DIGIT. Otherwise the byte must equal TAGS[fi] to go to DIGIT; else error BAD_TAG (1).
- DIGIT: the byte must be `0`..`9`, else BAD_DIGIT (2).
  - Accumulate acc = acc*10 + d, computed in VAL_W+4 bits.
  - If acc > MAX_VAL (RGB) or acc > LED_MAX (LED), raise RANGE (3) immediately at that digit.
  - Increment the digit count dc. When dc reaches DIGITS, store acc into a staging register and go to SEP.
- SEP, RGB mode:
  - `,` with fi < N_FIELDS-1: fi++, acc=0, go to TAG.
  - `}` with fi == N_FIELDS-1: copy staging to rgb_fields, pulse rgb_ready, go to IDLE.
  - Anything else: BAD_SEP (4).
- SEP, LED mode:
  - `}` with acc >= LED_MIN: load led_command, pulse led_cmd_ready, go to IDLE.
  - `}` with acc < LED_MIN: RANGE (3).
  - Anything else: BAD_SEP (4).
- Resync: `{` received in any non-IDLE state pulses frame_err with RESYNC (6), then restarts at TAG with cleared accumulators. The `{` is not lost.
- Timeout:
  - The counter runs while busy and clears on every rx_done.
  - When it reaches TIMEOUT_CYC-1 without an rx_done, raise TIMEOUT (5) and go to IDLE.
  - If rx_done arrives in the same cycle as the expiry, the byte wins and no timeout is raised.
- Any error:
  - Pulse frame_err, latch err_code, go to IDLE (except RESYNC, which goes to TAG).
  - Staging is discarded; rgb_fields and led_command keep their last good values.
- Only one of rgb_ready, led_cmd_ready and frame_err pulses in any cycle.
- Partial RGB updates never reach rgb_fields: all fields are committed together.

Decomposition:
- Package msg_frame_pkg:
  - ASCII constants: LBRACE, RBRACE, COMMA, CH_L, CH_0, CH_9.
  - err_t enum (3-bit): NONE=0, BAD_TAG, BAD_DIGIT, RANGE, BAD_SEP, TIMEOUT, RESYNC.
  - state_t enum: IDLE, TAG, DIGIT, SEP.
- Sub-module dec_field_acc:
  - Handles the digit check, decimal accumulation, range compare against a runtime limit input, and the digit counter.
  - Ports: clr, en, byte, limit, acc, done, is_digit, over.
  - Instantiated once and shared by RGB and LED modes.

Test Plan:
- `{R255,G000,B128}` with defaults -> one rgb_ready pulse, rgb_fields=24'h8000FF (field0=0xFF, field1=0x00, field2=0x80); frame_err is never pulsed.
- `{L017}` -> led_command=17 and led_cmd_ready pulse. `{L015}` -> frame_err with err_code=3 at `}`, and led_command is unchanged.
- `{R256` -> frame_err with err_code=3 one cycle after the `6`. A following `{G` gives err_code=1. rgb_fields keep their prior value.
- `{R12{L016}` -> frame_err with err_code=6 at the second `{`, then led_command=16 and led_cmd_ready one cycle after `}`.
- `{R1` then no bytes for TIMEOUT_CYC cycles (bench sets TIMEOUT_CYC=50) -> frame_err with err_code=5 and busy low. Also: an rx_done on exactly cycle 49 gives no timeout.
- N_FIELDS=2, DIGITS=2, MAX_VAL=99, TAGS={"Y","X"}: `{X07,Y99}` -> rgb_fields={7'd99,7'd7}. Reset asserted after `{X0` -> all outputs 0 and busy low next cycle, with no frame_err.

Source files
------------

// File: rtl/msg_frame_pkg.sv
// Shared definitions for the ASCII message frame parser.
// Holds the ASCII byte constants, the error-cause encoding reported on
// err_code, and the parser state encoding.
package msg_frame_pkg;

   localparam logic [7:0] LBRACE = 8'h7B;  // '{'
   localparam logic [7:0] RBRACE = 8'h7D;  // '}'
   localparam logic [7:0] COMMA  = 8'h2C;  // ','
   localparam logic [7:0] CH_L   = 8'h4C;  // 'L'
   localparam logic [7:0] CH_0   = 8'h30;  // '0'
   localparam logic [7:0] CH_9   = 8'h39;  // '9'

   typedef enum logic [2:0] {
      NONE      = 3'd0,
      BAD_TAG   = 3'd1,
      BAD_DIGIT = 3'd2,
      RANGE     = 3'd3,
      BAD_SEP   = 3'd4,
      TIMEOUT   = 3'd5,
      RESYNC    = 3'd6
   } err_t;

   typedef enum logic [1:0] {
      IDLE,
      TAG,
      DIGIT,
      SEP
   } state_t;

endpackage

// File: rtl/dec_field_acc.sv
// Decimal field accumulator shared by the RGB and LED paths of the parser.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clr_i       - clear accumulator and digit count (wins over en_i)
//   en_i        - accept byte_i as the next digit
//   byte_i      - candidate ASCII digit
//   limit_i     - largest legal accumulated value
//   acc_o       - accumulated value including byte_i as the next digit
//   done_o      - byte_i would be the last digit of the field
//   is_digit_o  - byte_i is '0'..'9'
//   over_o      - acc_o exceeds limit_i
module dec_field_acc
   import msg_frame_pkg::*;
#(
   parameter int unsigned DIGITS = 3,
   parameter int unsigned ACC_W  = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [7:0]       byte_i,
   input  logic [ACC_W-1:0] limit_i,
   output logic [ACC_W-1:0] acc_o,
   output logic             done_o,
   output logic             is_digit_o,
   output logic             over_o
);

   localparam int unsigned DC_W = $clog2(DIGITS + 1);

   logic [ACC_W-1:0] acc_q, acc_d, acc_nxt;
   logic [DC_W-1:0]  dc_q, dc_d;

   // ASCII digits are 0x30..0x39, so the low nibble is the digit value.
   // Width is sized so acc*10+9 cannot wrap for any in-range acc.
   always_comb begin
      is_digit_o = (byte_i >= CH_0) && (byte_i <= CH_9);
      acc_nxt    = (acc_q << 3) + (acc_q << 1) + ACC_W'(byte_i[3:0]);
      acc_o      = acc_nxt;
      over_o     = acc_nxt > limit_i;
      done_o     = dc_q == DC_W'(DIGITS - 1);
   end

   always_comb begin
      acc_d = acc_q;
      dc_d  = dc_q;
      if (clr_i) begin
         acc_d = '0;
         dc_d  = '0;
      end else if (en_i) begin
         acc_d = acc_nxt;
         dc_d  = dc_q + DC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         dc_q  <= '0;
      end else begin
         acc_q <= acc_d;
         dc_q  <= dc_d;
      end
   end

endmodule

// File: rtl/msg_frame_parser.sv
// Parses ASCII frames from a UART receiver: RGB frames {T0ddd,T1ddd,...}
// and LED frames {Lddd}, decoding fields to binary on the fly.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   rx_byte        - received byte, valid with rx_done
//   rx_done        - one-cycle byte strobe
//   rgb_fields     - decoded RGB fields, field i at [i*VAL_W +: VAL_W]
//   rgb_ready      - pulse, rgb_fields updated
//   led_command    - decoded LED command
//   led_cmd_ready  - pulse, led_command updated
//   shift_buff     - pulse per received byte
//   frame_err      - pulse on frame abort
//   err_code       - cause of the last error, held
//   busy           - frame in progress
module msg_frame_parser
   import msg_frame_pkg::*;
#(
   parameter int unsigned            N_FIELDS    = 3,
   parameter int unsigned            DIGITS      = 3,
   parameter int unsigned            MAX_VAL     = 255,
   parameter logic [N_FIELDS*8-1:0]  TAGS        = {"B", "G", "R"},
   parameter int unsigned            LED_MIN     = 16,
   parameter int unsigned            LED_MAX     = 17,
   parameter int unsigned            TIMEOUT_CYC = 100000,
   localparam int unsigned           VAL_W       = $clog2(MAX_VAL + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                rx_byte,
   input  logic                      rx_done,
   output logic [N_FIELDS*VAL_W-1:0] rgb_fields,
   output logic                      rgb_ready,
   output logic [7:0]                led_command,
   output logic                      led_cmd_ready,
   output logic                      shift_buff,
   output logic                      frame_err,
   output logic [2:0]                err_code,
   output logic                      busy
);

   localparam int unsigned ACC_W = VAL_W + 4;
   localparam int unsigned FI_W  = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [ACC_W-1:0] RGB_LIMIT = ACC_W'(MAX_VAL);
   localparam logic [ACC_W-1:0] LED_LIMIT = ACC_W'(LED_MAX);
   localparam logic [ACC_W-1:0] LED_FLOOR = ACC_W'(LED_MIN);
   localparam logic [FI_W-1:0]  LAST_FI   = FI_W'(N_FIELDS - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);

   state_t                    state_q, state_d;
   logic [FI_W-1:0]           fi_q, fi_d;
   logic                      led_mode_q, led_mode_d;
   logic [N_FIELDS*VAL_W-1:0] stage_q, stage_d;
   logic [ACC_W-1:0]          led_stage_q, led_stage_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [N_FIELDS*VAL_W-1:0] rgb_fields_q, rgb_fields_d;
   logic                      rgb_ready_q, rgb_ready_d;
   logic [7:0]                led_command_q, led_command_d;
   logic                      led_ready_q, led_ready_d;
   logic                      shift_q, shift_d;
   logic                      frame_err_q, frame_err_d;
   err_t                      err_code_q, err_code_d;
   err_t                      err;

   logic                      acc_clr, acc_en, acc_done, acc_is_digit, acc_over;
   logic [ACC_W-1:0]          acc_val, acc_limit;

   assign acc_limit = led_mode_q ? LED_LIMIT : RGB_LIMIT;

   dec_field_acc #(
      .DIGITS (DIGITS),
      .ACC_W  (ACC_W)
   ) u_acc (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (acc_clr),
      .en_i       (acc_en),
      .byte_i     (rx_byte),
      .limit_i    (acc_limit),
      .acc_o      (acc_val),
      .done_o     (acc_done),
      .is_digit_o (acc_is_digit),
      .over_o     (acc_over)
   );

   always_comb begin
      state_d       = state_q;
      fi_d          = fi_q;
      led_mode_d    = led_mode_q;
      stage_d       = stage_q;
      led_stage_d   = led_stage_q;
      rgb_fields_d  = rgb_fields_q;
      rgb_ready_d   = 1'b0;
      led_command_d = led_command_q;
      led_ready_d   = 1'b0;
      shift_d       = rx_done;
      frame_err_d   = 1'b0;
      err_code_d    = err_code_q;
      acc_clr       = 1'b0;
      acc_en        = 1'b0;
      err           = NONE;

      // Idle-gap counter; any byte restarts it.
      if (state_q == IDLE || rx_done) cnt_d = '0;
      else                            cnt_d = cnt_q + CNT_W'(1);

      if (rx_done) begin
         if (rx_byte == LBRACE) begin
            // '{' always starts a fresh frame; mid-frame it also aborts the old one.
            if (state_q != IDLE) err = RESYNC;
            state_d    = TAG;
            fi_d       = '0;
            led_mode_d = 1'b0;
            acc_clr    = 1'b1;
         end else begin
            unique case (state_q)
               IDLE: ;
               TAG: begin
                  if (fi_q == '0 && rx_byte == CH_L) begin
                     led_mode_d = 1'b1;
                     state_d    = DIGIT;
                  end else if (rx_byte == TAGS[fi_q*8 +: 8]) begin
                     state_d = DIGIT;
                  end else begin
                     err = BAD_TAG;
                  end
               end
               DIGIT: begin
                  if (!acc_is_digit) begin
                     err = BAD_DIGIT;
                  end else if (acc_over) begin
                     err = RANGE;
                  end else begin
                     acc_en = 1'b1;
                     if (acc_done) begin
                        if (led_mode_q) led_stage_d = acc_val;
                        else            stage_d[fi_q*VAL_W +: VAL_W] = acc_val[VAL_W-1:0];
                        state_d = SEP;
                     end
                  end
               end
               SEP: begin
                  if (led_mode_q) begin
                     if (rx_byte != RBRACE) begin
                        err = BAD_SEP;
                     end else if (led_stage_q < LED_FLOOR) begin
                        err = RANGE;
                     end else begin
                        led_command_d = 8'(led_stage_q);
                        led_ready_d   = 1'b1;
                        state_d       = IDLE;
                     end
                  end else if (rx_byte == COMMA && fi_q < LAST_FI) begin
                     fi_d    = fi_q + FI_W'(1);
                     acc_clr = 1'b1;
                     state_d = TAG;
                  end else if (rx_byte == RBRACE && fi_q == LAST_FI) begin
                     rgb_fields_d = stage_q;
                     rgb_ready_d  = 1'b1;
                     state_d      = IDLE;
                  end else begin
                     err = BAD_SEP;
                  end
               end
               default: ;
            endcase
         end
      end else if (state_q != IDLE && cnt_q == TO_LAST) begin
         // A byte arriving on the expiry cycle takes the branch above instead.
         err = TIMEOUT;
      end

      if (err != NONE) begin
         frame_err_d = 1'b1;
         err_code_d  = err;
         if (err != RESYNC) state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         fi_q          <= '0;
         led_mode_q    <= 1'b0;
         stage_q       <= '0;
         led_stage_q   <= '0;
         cnt_q         <= '0;
         rgb_fields_q  <= '0;
         rgb_ready_q   <= 1'b0;
         led_command_q <= '0;
         led_ready_q   <= 1'b0;
         shift_q       <= 1'b0;
         frame_err_q   <= 1'b0;
         err_code_q    <= NONE;
      end else begin
         state_q       <= state_d;
         fi_q          <= fi_d;
         led_mode_q    <= led_mode_d;
         stage_q       <= stage_d;
         led_stage_q   <= led_stage_d;
         cnt_q         <= cnt_d;
         rgb_fields_q  <= rgb_fields_d;
         rgb_ready_q   <= rgb_ready_d;
         led_command_q <= led_command_d;
         led_ready_q   <= led_ready_d;
         shift_q       <= shift_d;
         frame_err_q   <= frame_err_d;
         err_code_q    <= err_code_d;
      end
   end

   assign rgb_fields    = rgb_fields_q;
   assign rgb_ready     = rgb_ready_q;
   assign led_command   = led_command_q;
   assign led_cmd_ready = led_ready_q;
   assign shift_buff    = shift_q;
   assign frame_err     = frame_err_q;
   assign err_code      = err_code_q;
   assign busy          = state_q != IDLE;

endmodule

// File: tb/tb_msg_frame_parser.sv
// Directed bench for msg_frame_parser: default 3-field instance (a) and a
// 2-field, 2-digit instance (b). Both use a 50-cycle inter-byte timeout.
module tb_msg_frame_parser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Instance a: defaults except timeout.
   logic        a_reset = 1'b1;
   logic [7:0]  a_rx_byte = 8'h00;
   logic        a_rx_done = 1'b0;
   logic [23:0] a_rgb_fields;
   logic        a_rgb_ready, a_led_ready, a_shift, a_frame_err, a_busy;
   logic [7:0]  a_led_command;
   logic [2:0]  a_err_code;

   msg_frame_parser #(
      .TIMEOUT_CYC (50)
   ) dut_a (
      .clk           (clk),
      .reset         (a_reset),
      .rx_byte       (a_rx_byte),
      .rx_done       (a_rx_done),
      .rgb_fields    (a_rgb_fields),
      .rgb_ready     (a_rgb_ready),
      .led_command   (a_led_command),
      .led_cmd_ready (a_led_ready),
      .shift_buff    (a_shift),
      .frame_err     (a_frame_err),
      .err_code      (a_err_code),
      .busy          (a_busy)
   );

   // Instance b: 2 fields of 2 digits, MAX_VAL 99 -> 7-bit fields.
   logic        b_reset = 1'b1;
   logic [7:0]  b_rx_byte = 8'h00;
   logic        b_rx_done = 1'b0;
   logic [13:0] b_rgb_fields;
   logic        b_rgb_ready, b_led_ready, b_shift, b_frame_err, b_busy;
   logic [7:0]  b_led_command;
   logic [2:0]  b_err_code;

   msg_frame_parser #(
      .N_FIELDS    (2),
      .DIGITS      (2),
      .MAX_VAL     (99),
      .TAGS        ({"Y", "X"}),
      .TIMEOUT_CYC (50)
   ) dut_b (
      .clk           (clk),
      .reset         (b_reset),
      .rx_byte       (b_rx_byte),
      .rx_done       (b_rx_done),
      .rgb_fields    (b_rgb_fields),
      .rgb_ready     (b_rgb_ready),
      .led_command   (b_led_command),
      .led_cmd_ready (b_led_ready),
      .shift_buff    (b_shift),
      .frame_err     (b_frame_err),
      .err_code      (b_err_code),
      .busy          (b_busy)
   );

   // Pulse counters; a pulse is counted on the edge after it appears.
   int a_err_pulses = 0;
   int a_rgb_pulses = 0;
   int b_err_pulses = 0;
   always @(posedge clk) begin
      if (a_frame_err) a_err_pulses <= a_err_pulses + 1;
      if (a_rgb_ready) a_rgb_pulses <= a_rgb_pulses + 1;
      if (b_frame_err) b_err_pulses <= b_err_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on the negedge after the sampling posedge, so registered
   // responses to this byte are visible on return.
   task automatic send_a(input logic [7:0] b);
      @(negedge clk);
      a_rx_byte = b;
      a_rx_done = 1'b1;
      @(negedge clk);
      a_rx_done = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      @(negedge clk);
      b_rx_byte = b;
      b_rx_done = 1'b1;
      @(negedge clk);
      b_rx_done = 1'b0;
   endtask

   task automatic str_a(input string s);
      for (int i = 0; i < s.len(); i++) send_a(s[i]);
   endtask

   task automatic str_b(input string s);
      for (int i = 0; i < s.len(); i++) send_b(s[i]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      idle(3);
      a_reset = 1'b0;
      b_reset = 1'b0;

      // Reset state
      check("a_reset_rgb", a_rgb_fields, 24'h0);
      check("a_reset_led", a_led_command, 8'd0);
      check("a_reset_busy", a_busy, 1'b0);
      check("a_reset_err", {a_frame_err, a_err_code}, 4'h0);
      check("a_reset_pulses", {a_rgb_ready, a_led_ready, a_shift}, 3'b000);

      // Good RGB frame
      e0 = a_err_pulses;
      str_a("{R255,G000,B128}");
      check("rgb_ready", a_rgb_ready, 1'b1);
      check("rgb_fields", a_rgb_fields, 24'h8000FF);
      check("rgb_shift", a_shift, 1'b1);
      check("rgb_idle", a_busy, 1'b0);
      idle(1);
      check("rgb_ready_width", a_rgb_ready, 1'b0);
      idle(1);
      check("rgb_no_err", a_err_pulses - e0, 0);
      check("rgb_one_pulse", a_rgb_pulses, 1);

      // LED frames
      str_a("{L017}");
      check("led_ready", a_led_ready, 1'b1);
      check("led_cmd", a_led_command, 8'd17);
      str_a("{L015}");
      check("led_low_err", {a_frame_err, a_err_code}, {1'b1, 3'd3});
      check("led_low_keep", a_led_command, 8'd17);
      check("led_low_noready", a_led_ready, 1'b0);

      // Range error on the offending digit, then bad tag
      str_a("{R25");
      check("range_not_yet", a_frame_err, 1'b0);
      send_a("6");
      check("range_err", {a_frame_err, a_err_code}, {1'b1, 3'd3});
      check("range_idle", a_busy, 1'b0);
      str_a("{G");
      check("bad_tag", {a_frame_err, a_err_code}, {1'b1, 3'd1});
      check("bad_tag_keep", a_rgb_fields, 24'h8000FF);
      idle(1);
      check("err_code_held", {a_frame_err, a_err_code}, {1'b0, 3'd1});

      str_a("{R2x");
      check("bad_digit", {a_frame_err, a_err_code}, {1'b1, 3'd2});

      // Resync on '{' mid-frame
      str_a("{R12{");
      check("resync_err", {a_frame_err, a_err_code}, {1'b1, 3'd6});
      check("resync_busy", a_busy, 1'b1);
      str_a("L016}");
      check("resync_led", {a_led_ready, a_led_command}, {1'b1, 8'd16});

      // Timeout after 50 idle cycles
      str_a("{R1");
      idle(49);
      check("timeout_early", a_frame_err, 1'b0);
      idle(1);
      check("timeout_err", {a_frame_err, a_err_code}, {1'b1, 3'd5});
      check("timeout_idle", a_busy, 1'b0);

      // Byte arriving on the expiry cycle wins
      idle(2);
      e0 = a_err_pulses;
      str_a("{R1");
      idle(48);
      send_a("2");
      check("to_edge_noerr", a_frame_err, 1'b0);
      check("to_edge_busy", a_busy, 1'b1);
      str_a("3,G000,B000}");
      check("to_edge_rgb", {a_rgb_ready, a_rgb_fields}, {1'b1, 24'h00007B});
      idle(1);
      check("to_edge_no_pulse", a_err_pulses - e0, 0);

      // Instance b
      check("b_reset_rgb", b_rgb_fields, 14'h0);
      str_b("{X07,Y99}");
      check("b_rgb", {b_rgb_ready, b_rgb_fields}, {1'b1, 14'd12679});
      str_b("{X07}");
      check("b_bad_sep", {b_frame_err, b_err_code}, {1'b1, 3'd4});
      check("b_bad_sep_keep", b_rgb_fields, 14'd12679);
      idle(2);
      e0 = b_err_pulses;
      str_b("{X0");
      check("b_mid_busy", b_busy, 1'b1);
      @(negedge clk);
      b_reset = 1'b1;
      @(negedge clk);
      b_reset = 1'b0;
      check("b_rst_rgb", b_rgb_fields, 14'h0);
      check("b_rst_out", {b_busy, b_frame_err, b_err_code, b_rgb_ready, b_led_ready},
            7'h00);
      idle(2);
      check("b_rst_no_err", b_err_pulses - e0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
